// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external ALU between two requesters.
// Each requester owns a response FIFO, and a registered credit counter keeps that FIFO from overflowing.
module alu_arbiter #(
    parameter int ALU_LAT    = 1,
    parameter int RESP_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_req0_valid,
    output logic        io_req0_ready,
    input  logic [15:0] io_req0_a,
    input  logic [15:0] io_req0_b,
    input  logic [2:0]  io_req0_op,
    input  logic        io_req1_valid,
    output logic        io_req1_ready,
    input  logic [15:0] io_req1_a,
    input  logic [15:0] io_req1_b,
    input  logic [2:0]  io_req1_op,
    output logic        io_resp0_valid,
    input  logic        io_resp0_ready,
    output logic [15:0] io_resp0_result,
    output logic        io_resp1_valid,
    input  logic        io_resp1_ready,
    output logic [15:0] io_resp1_result,
    output logic [15:0] io_alu_a,
    output logic [15:0] io_alu_b,
    output logic [2:0]  io_alu_aluOp,
    input  logic [15:0] io_alu_result,
    output logic        io_busy
);

    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(RESP_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(RESP_DEPTH - 1);

    logic [1:0]    req_valid, resp_ready, elig, contend, accept, push, pop, fifo_nonempty;
    logic [CW-1:0] credit_cnt [2];
    logic [CW-1:0] fifo_cnt [2];
    logic [PW-1:0] wr_ptr [2];
    logic [PW-1:0] rd_ptr [2];
    logic [15:0]   fifo_mem [2][RESP_DEPTH];
    logic          rr_last;
    logic          iss_valid, iss_tag;
    logic [15:0]   iss_a, iss_b;
    logic [2:0]    iss_op;
    logic          wb_valid, wb_tag, pipe_busy;

    assign req_valid  = {io_req1_valid, io_req0_valid};
    assign resp_ready = {io_resp1_ready, io_resp0_ready};

    // Gating with reset keeps ready low for as long as reset is held.
    always_comb begin
        elig          = '0;
        fifo_nonempty = '0;
        for (int i = 0; i < 2; i++) begin
            elig[i]          = reset && (credit_cnt[i] < DEPTH_C);
            fifo_nonempty[i] = (fifo_cnt[i] != '0);
        end
    end

    // rr_last holds the requester granted most recently; on a tie the other requester wins.
    assign contend       = req_valid & elig;
    assign io_req0_ready = elig[0] & ~(contend[1] & ~rr_last);
    assign io_req1_ready = elig[1] & ~(contend[0] & rr_last);
    assign accept        = req_valid & {io_req1_ready, io_req0_ready};
    assign pop           = fifo_nonempty & resp_ready;
    assign push          = {wb_valid & wb_tag, wb_valid & ~wb_tag};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_last   <= 1'b1;
            iss_valid <= 1'b0;
            iss_tag   <= 1'b0;
            iss_a     <= '0;
            iss_b     <= '0;
            iss_op    <= '0;
        end else begin
            iss_valid <= |accept;
            iss_tag   <= accept[1];
            if (accept[0]) begin
                iss_a  <= io_req0_a;
                iss_b  <= io_req0_b;
                iss_op <= io_req0_op;
            end else if (accept[1]) begin
                iss_a  <= io_req1_a;
                iss_b  <= io_req1_b;
                iss_op <= io_req1_op;
            end else begin
                iss_a  <= '0;
                iss_b  <= '0;
                iss_op <= '0;
            end
            if (accept[1]) begin
                rr_last <= 1'b1;
            end else if (accept[0]) begin
                rr_last <= 1'b0;
            end
        end
    end

    generate
        if (ALU_LAT == 0) begin : g_comb_alu
            assign wb_valid  = iss_valid;
            assign wb_tag    = iss_tag;
            assign pipe_busy = 1'b0;
        end else begin : g_tag_pipe
            logic [ALU_LAT-1:0] pipe_v, pipe_t;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    pipe_v <= '0;
                    pipe_t <= '0;
                end else begin
                    pipe_v[0] <= iss_valid;
                    pipe_t[0] <= iss_tag;
                    for (int k = 1; k < ALU_LAT; k++) begin
                        pipe_v[k] <= pipe_v[k-1];
                        pipe_t[k] <= pipe_t[k-1];
                    end
                end
            end
            assign wb_valid  = pipe_v[ALU_LAT-1];
            assign wb_tag    = pipe_t[ALU_LAT-1];
            assign pipe_busy = |pipe_v;
        end
    endgenerate

    // A credit is taken at accept and handed back only on the edge that follows the pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                credit_cnt[i] <= '0;
                fifo_cnt[i]   <= '0;
                wr_ptr[i]     <= '0;
                rd_ptr[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (accept[i] && !pop[i]) begin
                    credit_cnt[i] <= credit_cnt[i] + 1'b1;
                end else if (!accept[i] && pop[i]) begin
                    credit_cnt[i] <= credit_cnt[i] - 1'b1;
                end
                if (push[i] && !pop[i]) begin
                    fifo_cnt[i] <= fifo_cnt[i] + 1'b1;
                end else if (!push[i] && pop[i]) begin
                    fifo_cnt[i] <= fifo_cnt[i] - 1'b1;
                end
                if (push[i]) begin
                    wr_ptr[i] <= (wr_ptr[i] == LAST_PTR) ? '0 : wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= (rd_ptr[i] == LAST_PTR) ? '0 : rd_ptr[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_ptr[i]] <= io_alu_result;
            end
        end
    end

    assign io_resp0_valid  = fifo_nonempty[0];
    assign io_resp1_valid  = fifo_nonempty[1];
    assign io_resp0_result = fifo_nonempty[0] ? fifo_mem[0][rd_ptr[0]] : '0;
    assign io_resp1_result = fifo_nonempty[1] ? fifo_mem[1][rd_ptr[1]] : '0;
    assign io_alu_a        = iss_a;
    assign io_alu_b        = iss_b;
    assign io_alu_aluOp    = iss_op;
    assign io_busy         = iss_valid | pipe_busy | (|fifo_nonempty);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a queue-based reference model checked every cycle, directed scenarios,
// random traffic, and a second instance built with a combinational ALU.
module tb_alu_arbiter;

    localparam int LAT   = 1;
    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [15:0] resp0_result, resp1_result;
    logic [15:0] alu_a, alu_b, alu_res;
    logic [2:0]  alu_op;
    logic        busy;

    logic        l0_req1_valid, l0_req0_ready, l0_req1_ready;
    logic [15:0] l0_req1_a, l0_req1_b;
    logic [2:0]  l0_req1_op;
    logic        l0_resp0_valid, l0_resp1_valid;
    logic [15:0] l0_resp0_result, l0_resp1_result;
    logic [15:0] l0_alu_a, l0_alu_b, l0_alu_res;
    logic [2:0]  l0_alu_op;
    logic        l0_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    alu_arbiter #(.ALU_LAT(LAT), .RESP_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .io_req0_valid(req0_valid), .io_req0_ready(req0_ready),
        .io_req0_a(req0_a), .io_req0_b(req0_b), .io_req0_op(req0_op),
        .io_req1_valid(req1_valid), .io_req1_ready(req1_ready),
        .io_req1_a(req1_a), .io_req1_b(req1_b), .io_req1_op(req1_op),
        .io_resp0_valid(resp0_valid), .io_resp0_ready(resp0_ready), .io_resp0_result(resp0_result),
        .io_resp1_valid(resp1_valid), .io_resp1_ready(resp1_ready), .io_resp1_result(resp1_result),
        .io_alu_a(alu_a), .io_alu_b(alu_b), .io_alu_aluOp(alu_op),
        .io_alu_result(alu_res), .io_busy(busy)
    );

    alu_arbiter #(.ALU_LAT(0), .RESP_DEPTH(2)) dut_l0 (
        .clock(clock), .reset(reset),
        .io_req0_valid(1'b0), .io_req0_ready(l0_req0_ready),
        .io_req0_a(16'd0), .io_req0_b(16'd0), .io_req0_op(3'd0),
        .io_req1_valid(l0_req1_valid), .io_req1_ready(l0_req1_ready),
        .io_req1_a(l0_req1_a), .io_req1_b(l0_req1_b), .io_req1_op(l0_req1_op),
        .io_resp0_valid(l0_resp0_valid), .io_resp0_ready(1'b1), .io_resp0_result(l0_resp0_result),
        .io_resp1_valid(l0_resp1_valid), .io_resp1_ready(1'b1), .io_resp1_result(l0_resp1_result),
        .io_alu_a(l0_alu_a), .io_alu_b(l0_alu_b), .io_alu_aluOp(l0_alu_op),
        .io_alu_result(l0_alu_res), .io_busy(l0_busy)
    );

    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0:    return a;
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return b;
            default: return a >> 1;
        endcase
    endfunction

    // External ALU models: one register stage for the main instance, combinational for dut_l0.
    always @(posedge clock) alu_res <= alu_f(alu_op, alu_a, alu_b);
    assign l0_alu_res = alu_f(l0_alu_op, l0_alu_a, l0_alu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] val;
        int          avail;
    } ent_t;

    ent_t        mq0[$];
    ent_t        mq1[$];
    logic [15:0] obs0[$];
    logic [15:0] obs1[$];
    int          cyc = 0;
    int          last_gnt = 1;
    logic [15:0] exp_a = '0, exp_b = '0;
    logic [2:0]  exp_op = '0;

    // Reference model: each accepted op becomes a queue entry that is visible 2+LAT cycles later and leaves when popped.
    always @(negedge clock) begin : monitor
        logic v0e, v1e, e0, e1, r0e, r1e;
        logic [15:0] res0e, res1e;
        cyc++;
        if (!reset) begin
            check("reset_outputs", {req0_ready, req1_ready, resp0_valid, resp1_valid, busy,
                  |resp0_result, |resp1_result, |alu_a, |alu_b, |alu_op}, 32'd0);
            mq0.delete();
            mq1.delete();
            last_gnt = 1;
            exp_a = '0;
            exp_b = '0;
            exp_op = '0;
        end else begin
            v0e   = (mq0.size() > 0) && (mq0[0].avail <= cyc);
            v1e   = (mq1.size() > 0) && (mq1[0].avail <= cyc);
            res0e = v0e ? mq0[0].val : 16'd0;
            res1e = v1e ? mq1[0].val : 16'd0;
            e0    = mq0.size() < DEPTH;
            e1    = mq1.size() < DEPTH;
            r0e   = e0 && !(req1_valid && e1 && last_gnt == 0);
            r1e   = e1 && !(req0_valid && e0 && last_gnt == 1);
            check("req0_ready", req0_ready, r0e);
            check("req1_ready", req1_ready, r1e);
            check("resp0_valid", resp0_valid, v0e);
            check("resp1_valid", resp1_valid, v1e);
            check("resp0_result", resp0_result, res0e);
            check("resp1_result", resp1_result, res1e);
            check("alu_a", alu_a, exp_a);
            check("alu_b", alu_b, exp_b);
            check("alu_op", alu_op, exp_op);
            check("busy", busy, (mq0.size() + mq1.size()) > 0);
            if (resp0_valid && resp0_ready) obs0.push_back(resp0_result);
            if (resp1_valid && resp1_ready) obs1.push_back(resp1_result);
            if (v0e && resp0_ready) void'(mq0.pop_front());
            if (v1e && resp1_ready) void'(mq1.pop_front());
            if (req0_valid && r0e) begin
                mq0.push_back('{alu_f(req0_op, req0_a, req0_b), cyc + 2 + LAT});
                last_gnt = 0;
                exp_a = req0_a;
                exp_b = req0_b;
                exp_op = req0_op;
            end else if (req1_valid && r1e) begin
                mq1.push_back('{alu_f(req1_op, req1_a, req1_b), cyc + 2 + LAT});
                last_gnt = 1;
                exp_a = req1_a;
                exp_b = req1_b;
                exp_op = req1_op;
            end else begin
                exp_a = '0;
                exp_b = '0;
                exp_op = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send0(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bit got;
        got = 0;
        req0_valid = 1'b1;
        req0_op = op;
        req0_a = a;
        req0_b = b;
        for (int i = 0; i < 20 && !got; i++) begin
            #2;
            if (req0_ready) got = 1;
            tick();
        end
        if (!got) check("send0_timeout", 32'd0, 32'd1);
    endtask

    initial begin : driver
        logic [2:0]  prev_op, now_op;
        int          acc1;
        logic [15:0] exp_sweep [9];
        exp_sweep = '{16'd12, 16'd17, 16'd7, 16'd4, 16'd13, 16'd9, 16'd5, 16'd6, 16'hFFF9};
        prev_op = '0;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        resp0_ready = 1; resp1_ready = 1;
        l0_req1_valid = 0; l0_req1_a = 0; l0_req1_b = 0; l0_req1_op = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // Single ADD on requester 0.
        req0_valid = 1; req0_op = 3'd1; req0_a = 16'd12; req0_b = 16'd5;
        #2 check("t1_ready", req0_ready, 1);
        tick(); req0_valid = 0;
        #2 check("t1_alu_op", alu_op, 1);
        check("t1_alu_a", alu_a, 12);
        tick(); #2 check("t1_resp_early", resp0_valid, 0);
        tick(); #2 check("t1_resp_valid", resp0_valid, 1);
        check("t1_result", resp0_result, 17);
        tick(); #2 check("t1_busy_after_pop", busy, 0);

        // Contention: grants must alternate, starting with requester 1.
        tick();
        obs0.delete(); obs1.delete();
        req0_valid = 1; req0_op = 3'd1; req0_a = 16'd12; req0_b = 16'd5;
        req1_valid = 1; req1_op = 3'd2; req1_a = 16'd12; req1_b = 16'd5;
        for (int i = 0; i < 8; i++) begin
            tick(); #2;
            now_op = alu_op;
            if (i == 0) check("t2_first_grant", now_op, 2);
            else check("t2_alternate", now_op != prev_op, 1);
            prev_op = now_op;
        end
        req0_valid = 0; req1_valid = 0;
        repeat (6) tick();
        check("t2_count0", obs0.size(), 4);
        check("t2_count1", obs1.size(), 4);
        for (int i = 0; i < obs0.size(); i++) check("t2_val0", obs0[i], 17);
        for (int i = 0; i < obs1.size(); i++) check("t2_val1", obs1[i], 7);

        // Backpressure on response 1 must throttle only requester 1.
        obs1.delete();
        resp1_ready = 0;
        req1_valid = 1; req1_op = 3'd5; req1_a = 16'd12; req1_b = 16'd5;
        req0_valid = 1; req0_op = 3'd3; req0_a = 16'd12; req0_b = 16'd5;
        acc1 = 0;
        for (int i = 0; i < 10; i++) begin
            #2 if (req1_valid && req1_ready) acc1++;
            tick();
        end
        #2 check("t3_accepted", acc1, 2);
        check("t3_blocked", req1_ready, 0);
        check("t3_head_valid", resp1_valid, 1);
        check("t3_head", resp1_result, 9);
        resp1_ready = 1; req0_valid = 0;
        acc1 = 0;
        for (int i = 0; i < 8; i++) begin
            tick(); #2;
            if (req1_valid && req1_ready) acc1++;
        end
        check("t3_resumed", acc1 >= 1, 1);
        tick(); req1_valid = 0;
        repeat (8) tick();
        check("t3_first", obs1.size() >= 2 ? obs1[0] : 16'hDEAD, 9);
        check("t3_second", obs1.size() >= 2 ? obs1[1] : 16'hDEAD, 9);

        // Op sweep with a=12 b=5, then a wrapping SUB.
        obs0.delete();
        for (int op = 0; op < 8; op++) send0(3'(op), 16'd12, 16'd5);
        send0(3'd2, 16'd5, 16'd12);
        req0_valid = 0;
        repeat (8) tick();
        check("t4_count", obs0.size(), 9);
        for (int i = 0; i < 9 && i < obs0.size(); i++) check("t4_result", obs0[i], exp_sweep[i]);

        // Reset with operations in flight.
        tick();
        req0_valid = 1; req0_op = 3'd1; req0_a = 16'd3; req0_b = 16'd4;
        tick(); req0_op = 3'd2;
        tick();
        reset = 1'b0; req0_valid = 0;
        #1 check("t5_outs_zero", {req0_ready, req1_ready, resp0_valid, resp1_valid, busy,
                 |resp0_result, |alu_a, |alu_b, |alu_op}, 32'd0);
        tick(); tick();
        reset = 1'b1;
        req0_valid = 1; req0_op = 3'd1; req0_a = 16'd1; req0_b = 16'd1;
        #2 check("t5_ready", req0_ready, 1);
        tick(); req0_valid = 0;
        #2 check("t5_no_stale1", resp0_valid, 0);
        tick(); #2 check("t5_no_stale2", resp0_valid, 0);
        tick(); #2 check("t5_valid", resp0_valid, 1);
        check("t5_result", resp0_result, 2);

        // Combinational-ALU instance: OR result two cycles after accept.
        tick();
        l0_req1_valid = 1; l0_req1_op = 3'd4; l0_req1_a = 16'd12; l0_req1_b = 16'd5;
        #2 check("t6_ready", l0_req1_ready, 1);
        tick(); l0_req1_valid = 0;
        #2 check("t6_early", l0_resp1_valid, 0);
        tick(); #2 check("t6_valid", l0_resp1_valid, 1);
        check("t6_result", l0_resp1_result, 13);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            tick();
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_op = 3'($urandom_range(0, 7));
            req1_op = 3'($urandom_range(0, 7));
            req0_a = 16'($urandom); req0_b = 16'($urandom);
            req1_a = 16'($urandom); req1_b = 16'($urandom);
            resp0_ready = ($urandom_range(0, 3) != 0);
            resp1_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        req0_valid = 0; req1_valid = 0; resp0_ready = 1; resp1_ready = 1;
        repeat (10) tick();
        #2 check("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
